// File: rtl/lutram_bist_pkg.sv
// Shared state encoding, data constants and the address-dependent test
// pattern used by the LUTRAM BIST sequencer and its compare stage.
package lutram_bist_pkg;

  localparam int DATA_W    = 10;
  localparam int LUT_DEPTH = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Pattern for one word: low address bits, XOR seed, optionally inverted.
  function automatic logic [DATA_W-1:0] pat(input logic [DATA_W-1:0] addr_lo,
                                            input logic [DATA_W-1:0] seed,
                                            input logic              inv);
    return addr_lo ^ seed ^ {DATA_W{inv}};
  endfunction

endpackage

// File: rtl/lutram_bist_cmp.sv
// One-stage read-compare pipeline with saturating error counter and
// sticky fail flag that captures the address of the first mismatch.
module lutram_bist_cmp
  import lutram_bist_pkg::*;
#(
  parameter int AW    = 13,
  parameter int ERR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              vld_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DATA_W-1:0] rdat_i,
  input  logic [DATA_W-1:0] exp_i,
  output logic              fail_o,
  output logic [ERR_W-1:0]  err_cnt_o,
  output logic [AW-1:0]     first_err_addr_o
);

  logic              vld_q;
  logic [AW-1:0]     addr_q;
  logic [DATA_W-1:0] rdat_q;
  logic [DATA_W-1:0] exp_q;
  logic              fail_q, fail_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [AW-1:0]     first_q, first_d;
  logic              mismatch;

  // Capture the word read this cycle together with its expected value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= 1'b0;
      addr_q <= '0;
      rdat_q <= '0;
      exp_q  <= '0;
    end else begin
      vld_q  <= vld_i;
      addr_q <= addr_i;
      rdat_q <= rdat_i;
      exp_q  <= exp_i;
    end
  end

  // Result update: clear on a new test, otherwise count and record mismatches.
  always_comb begin
    mismatch = vld_q && (rdat_q != exp_q);
    fail_d   = fail_q;
    err_d    = err_q;
    first_d  = first_q;
    if (clr_i) begin
      fail_d  = 1'b0;
      err_d   = '0;
      first_d = '0;
    end else if (mismatch) begin
      if (err_q != {ERR_W{1'b1}}) begin
        err_d = err_q + ERR_W'(1);
      end
      if (!fail_q) begin
        fail_d  = 1'b1;
        first_d = addr_q;
      end
    end
  end

  // Result registers hold until the next accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fail_q  <= 1'b0;
      err_q   <= '0;
      first_q <= '0;
    end else begin
      fail_q  <= fail_d;
      err_q   <= err_d;
      first_q <= first_d;
    end
  end

  assign fail_o           = fail_q;
  assign err_cnt_o        = err_q;
  assign first_err_addr_o = first_q;

endmodule

// File: rtl/lutram_bist_ctrl.sv
// BIST sequencer for the LUTRAM stress array: writes a seeded pattern to
// every word, reads it back and counts mismatches.
// Optional feature macro LUTRAM_BIST_INVERT_PASS_EN adds a second pass
// with the pattern inverted so each bit is exercised at both polarities.
module lutram_bist_ctrl
  import lutram_bist_pkg::*;
#(
  parameter  int LUTRAM16X10 = 314,
  parameter  int ERR_W       = 16,
  localparam int N           = LUTRAM16X10 * LUT_DEPTH,
  localparam int AW          = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [DATA_W-1:0] seed_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              fail_o,
  output logic [ERR_W-1:0]  err_cnt_o,
  output logic [AW-1:0]     first_err_addr_o,
  output logic [AW-1:0]     mem_addr_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_wdat_o,
  input  logic [DATA_W-1:0] mem_rdat_i
);

  state_t            state_q, state_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdat_q, wdat_d;
  logic [DATA_W-1:0] seed_q, seed_d;
  logic              inv_q, inv_d;
  logic              second_pass_pending;
  logic              clr;
  logic              last_addr;
  logic [DATA_W-1:0] exp_pat;

  // Wrap on the real last word; depth need not be a power of two.
  assign last_addr = (addr_q == AW'(N - 1));

`ifdef LUTRAM_BIST_INVERT_PASS_EN
  // Pass polarity: cleared on start, set when the first pass drains.
  always_comb begin
    inv_d = inv_q;
    if (state_q == IDLE && start_i) begin
      inv_d = 1'b0;
    end else if (state_q == DRAIN && !inv_q) begin
      inv_d = 1'b1;
    end
  end

  // Polarity register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inv_q <= 1'b0;
    end else begin
      inv_q <= inv_d;
    end
  end

  assign second_pass_pending = ~inv_q;
`else
  assign inv_q               = 1'b0;
  assign inv_d               = 1'b0;
  assign second_pass_pending = 1'b0;
`endif

  // Next-state, address counter and registered array-port values.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = 1'b0;
    wdat_d  = wdat_q;
    seed_d  = seed_q;
    clr     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = WRITE;
          seed_d  = seed_i;
          addr_d  = '0;
          we_d    = 1'b1;
          clr     = 1'b1;
        end
      end
      WRITE: begin
        if (last_addr) begin
          addr_d  = '0;
          state_d = READ;
        end else begin
          addr_d = addr_q + AW'(1);
          we_d   = 1'b1;
        end
      end
      READ: begin
        if (last_addr) begin
          addr_d  = '0;
          state_d = DRAIN;
        end else begin
          addr_d = addr_q + AW'(1);
        end
      end
      DRAIN: begin
        if (second_pass_pending) begin
          addr_d  = '0;
          we_d    = 1'b1;
          state_d = WRITE;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (we_d) begin
      wdat_d = pat(DATA_W'(addr_d), seed_d, inv_d);
    end
  end

  // State and array-port registers; reset drops mem_we at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdat_q  <= '0;
      seed_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdat_q  <= wdat_d;
      seed_q  <= seed_d;
    end
  end

  assign exp_pat = pat(DATA_W'(addr_q), seed_q, inv_q);

  lutram_bist_cmp #(
    .AW    (AW),
    .ERR_W (ERR_W)
  ) u_cmp (
    .clk              (clk),
    .rst              (rst),
    .clr_i            (clr),
    .vld_i            (state_q == READ),
    .addr_i           (addr_q),
    .rdat_i           (mem_rdat_i),
    .exp_i            (exp_pat),
    .fail_o           (fail_o),
    .err_cnt_o        (err_cnt_o),
    .first_err_addr_o (first_err_addr_o)
  );

  assign busy_o     = (state_q == WRITE) || (state_q == READ) || (state_q == DRAIN);
  assign done_o     = (state_q == DONE);
  assign mem_addr_o = addr_q;
  assign mem_we_o   = we_q;
  assign mem_wdat_o = wdat_q;

endmodule

// File: tb/tb_lutram_bist_ctrl.sv
// Self-checking bench for lutram_bist_ctrl: a behavioural array with
// injectable read faults, a per-cycle reference model and a second small
// instance for counter saturation. Honours LUTRAM_BIST_INVERT_PASS_EN.
module tb_lutram_bist_ctrl;

  localparam int L16   = 314;
  localparam int N     = L16 * 16;
  localparam int AW    = $clog2(N);
  localparam int ERR_W = 16;
  localparam int SN    = 32;
  localparam int SAW   = 5;
  localparam int SERR  = 4;
`ifdef LUTRAM_BIST_INVERT_PASS_EN
  localparam int P        = 2;
  localparam int DONE_LIT = 20099;
`else
  localparam int P        = 1;
  localparam int DONE_LIT = 10050;
`endif
  localparam int L  = 2 * N + 1;
  localparam int SL = 2 * SN + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // main instance
  logic             start = 1'b0;
  logic [9:0]       seed  = '0;
  logic             busy, done, fail, mwe;
  logic [ERR_W-1:0] err;
  logic [AW-1:0]    first, maddr;
  logic [9:0]       mwdat, mrdat;

  lutram_bist_ctrl #(.LUTRAM16X10(L16), .ERR_W(ERR_W)) dut (
    .clk(clk), .rst(rst), .start_i(start), .seed_i(seed),
    .busy_o(busy), .done_o(done), .fail_o(fail), .err_cnt_o(err),
    .first_err_addr_o(first), .mem_addr_o(maddr), .mem_we_o(mwe),
    .mem_wdat_o(mwdat), .mem_rdat_i(mrdat));

  // small instance for saturation
  logic            s_start = 1'b0;
  logic [9:0]      s_seed  = '0;
  logic            s_busy, s_done, s_fail, s_mwe;
  logic [SERR-1:0] s_err;
  logic [SAW-1:0]  s_first, s_maddr;
  logic [9:0]      s_mwdat, s_mrdat;
  int              s_bad = 0;

  lutram_bist_ctrl #(.LUTRAM16X10(2), .ERR_W(SERR)) dut_s (
    .clk(clk), .rst(rst), .start_i(s_start), .seed_i(s_seed),
    .busy_o(s_busy), .done_o(s_done), .fail_o(s_fail), .err_cnt_o(s_err),
    .first_err_addr_o(s_first), .mem_addr_o(s_maddr), .mem_we_o(s_mwe),
    .mem_wdat_o(s_mwdat), .mem_rdat_i(s_mrdat));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [9:0] expat(input int a, input logic [9:0] s, input int p);
    logic [9:0] lo;
    lo = 10'(a % 1024);
    return lo ^ s ^ ((p != 0) ? 10'h3FF : 10'h000);
  endfunction

  // behavioural array with read faults
  logic [9:0] mem   [N];
  logic [9:0] fmask [N];
  int         fmode = 0;

  function automatic logic [9:0] faulty(input int a, input logic [9:0] d);
    logic [9:0] r;
    r = d;
    if (fmode == 1 && a == 37) r[0] = 1'b1;
    else if (fmode == 2) r = d ^ fmask[a];
    return r;
  endfunction

  always @(posedge clk) if (mwe) mem[maddr] <= mwdat;
  always_comb mrdat = faulty(int'(maddr), mem[maddr]);

  logic [9:0] smem [SN];
  always @(posedge clk) if (s_mwe) smem[s_maddr] <= s_mwdat;
  always_comb s_mrdat = smem[s_maddr] ^ ((int'(s_maddr) < s_bad) ? 10'h001 : 10'h000);

  // reference model: cycle index within a test, and predicted results
  int         t = 0;
  logic [9:0] m_seed = '0;
  int         m_err = 0, m_first = 0, p_err = 0, p_first = 0;
  logic       m_fail = 1'b0, p_fail = 1'b0;

  function automatic void predict(input logic [9:0] s);
    logic [9:0] w;
    p_err = 0; p_fail = 1'b0; p_first = 0;
    for (int p = 0; p < P; p++) begin
      for (int a = 0; a < N; a++) begin
        w = expat(a, s, p);
        if (faulty(a, w) != w) begin
          if (!p_fail) begin
            p_fail  = 1'b1;
            p_first = a;
          end
          if (p_err < (1 << ERR_W) - 1) p_err++;
        end
      end
    end
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      t = 0; m_err = 0; m_fail = 1'b0; m_first = 0;
    end else if (t == 0) begin
      if (start) begin
        t = 1; m_seed = seed; predict(seed);
        m_err = 0; m_fail = 1'b0; m_first = 0;
      end
    end else if (t == P * L + 1) begin
      t = 0;
    end else begin
      t = t + 1;
      if (t == P * L + 1) begin
        m_err = p_err; m_fail = p_fail; m_first = p_first;
      end
    end
  end

  // per-cycle compare against the model
  always @(negedge clk) begin
    int u, p;
    chk("busy", busy, (t >= 1 && t <= P * L));
    chk("done", done, (t == P * L + 1));
    if (t >= 1 && t <= P * L) begin
      u = (t - 1) % L;
      p = (t - 1) / L;
      chk("mem_we", mwe, (u < N));
      if (u < N) begin
        chk("wr_addr", maddr, u);
        chk("wdat", mwdat, expat(u, m_seed, p));
      end else if (u < 2 * N) begin
        chk("rd_addr", maddr, u - N);
      end
      if (t <= N) begin
        chk("err_cleared", err, 0);
        chk("fail_cleared", fail, 0);
      end
    end else begin
      chk("mem_we_idle", mwe, 0);
      chk("fail", fail, m_fail);
      chk("err_cnt", err, m_err);
      chk("first_err_addr", first, m_first);
    end
  end

  task automatic run(input logic [9:0] s, input int x1, input int x2,
                     input int rst_at, output int cyc);
    @(negedge clk);
    seed = s; start = 1'b1; cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      start = (cyc == x1 || cyc == x2);
      if (s == 10'h000 && cyc == N) chk("wdat_addr5023", mwdat, 10'h39F);
`ifdef LUTRAM_BIST_INVERT_PASS_EN
      if (s == 10'h0AA && cyc == 2 * N + 2) begin
        chk("inv_pass_we", mwe, 1);
        chk("inv_pass_addr0", maddr, 0);
        chk("inv_pass_wdat0", mwdat, 10'h355);
      end
`endif
      if (cyc == rst_at) begin
        #1 rst = 1'b1;
        #1;
        chk("arst_mem_we", mwe, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_fail", fail, 0);
        chk("arst_err", err, 0);
        chk("arst_first", first, 0);
        chk("arst_addr", maddr, 0);
        chk("arst_wdat", mwdat, 0);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        break;
      end
      if (done) break;
      if (cyc > P * L + 8) begin
        chk("done_timeout", 0, 1);
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic run_sat(input int nbad);
    int cyc, req;
    s_bad = nbad;
    @(negedge clk);
    s_seed = 10'($urandom_range(0, 1023)); s_start = 1'b1; cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      s_start = 1'b0;
      if (s_done) break;
      if (cyc > P * SL + 8) begin
        chk("sat_timeout", 0, 1);
        break;
      end
    end
    req = P * nbad;
    if (req > 15) req = 15;
    $display("sat run: nbad=%0d cyc=%0d err=%0d fail=%0d", nbad, cyc, s_err, s_fail);
    chk("sat_done_cycle", cyc, P * SL + 1);
    chk("sat_err_cnt", s_err, req);
    chk("sat_fail", s_fail, (nbad > 0));
    chk("sat_first", s_first, 0);
  endtask

  initial begin
    int cyc;
    logic [9:0] s4;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_mem_addr", maddr, 0);
    chk("rst_mem_wdat", mwdat, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    @(negedge clk);

    // clean run, seed 0
    fmode = 0;
    run(10'h000, -1, -1, -1, cyc);
    $display("run1: seed=000 done_cycle=%0d fail=%0d err=%0d", cyc, fail, err);
    chk("run1_done_cycle", cyc, DONE_LIT);
    chk("run1_fail", fail, 0);
    chk("run1_err", err, 0);

    // stuck-at-1 on bit 0 of addr 37, extra starts ignored
    fmode = 1;
    run(10'h3FF, 5, 3000, -1, cyc);
    $display("run2: seed=3FF done_cycle=%0d fail=%0d err=%0d first=%0d", cyc, fail, err, first);
    chk("run2_done_cycle", cyc, DONE_LIT);
    chk("run2_fail", fail, 1);
    chk("run2_err", err, 1);
    chk("run2_first", first, 37);
    repeat (4) @(negedge clk);

    // random faults, reset asserted during READ
    fmode = 2;
    for (int a = 0; a < N; a++) fmask[a] = 10'h000;
    for (int k = 0; k < 8; k++) fmask[$urandom_range(0, N - 1)] = 10'($urandom_range(1, 1023));
    run(10'($urandom_range(0, 1023)), -1, -1, N + 100, cyc);
    $display("run3: reset at cycle %0d", cyc);
    chk("run3_reset_cycle", cyc, N + 100);
    @(negedge clk);

    // random seed, random faults incl. first/last word, random stray starts
    for (int a = 0; a < N; a++) fmask[a] = 10'h000;
    fmask[0]     = 10'($urandom_range(1, 1023));
    fmask[N - 1] = 10'($urandom_range(1, 1023));
    for (int k = 0; k < 20; k++) fmask[$urandom_range(0, N - 1)] = 10'($urandom_range(1, 1023));
`ifdef LUTRAM_BIST_INVERT_PASS_EN
    s4 = 10'h0AA;
`else
    s4 = 10'($urandom_range(0, 1023));
`endif
    run(s4, $urandom_range(2, P * L), $urandom_range(2, P * L), -1, cyc);
    $display("run4: seed=%03h done_cycle=%0d fail=%0d err=%0d first=%0d", s4, cyc, fail, err, first);
    chk("run4_done_cycle", cyc, DONE_LIT);
    chk("run4_first", first, 0);
    repeat (3) @(negedge clk);

    // saturation on the small instance
    run_sat(32);
    run_sat(7);
    run_sat(0);
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
